// File: rtl/uart_pkt_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_pkt_pkg : shared types and helpers for the UART packet receiver     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    DROP = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Start + 8 data + stop, plus one bit when a parity bit is on the line.
  function automatic int frame_bits(input bit parity_en);
    return parity_en ? 11 : 10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_pkt_timeout.sv
// +--------------------------------------------------------------------------+
// | uart_pkt_timeout : inter-byte idle counter, pulses expire after LIMIT    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_pkt_timeout
  import uart_pkt_pkg::*;
#(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic rx_valid,
  input  logic rx_busy,
  output logic expire
);

  localparam int CW = (clog2(LIMIT) < 1) ? 1 : clog2(LIMIT);

  logic [CW-1:0] count;

  // A byte arriving in the expiry cycle wins over the timeout.
  assign expire = enable && !rx_valid && !rx_busy && (count == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || !enable || rx_valid || expire) begin
      count <= '0;
    end else if (!rx_busy) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_pkt_rx.sv
// +--------------------------------------------------------------------------+
// | uart_pkt_rx : cmd/len/data/chk packet receiver with RAM write port       |
// | Optional stats counters with UART_PKT_RX_STATS_EN.  Revision 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_pkt_rx
  import uart_pkt_pkg::*;
#(
  parameter int    CLOCK     = 10_000_000,
  parameter int    BAUD      = 1_000_000,
  parameter string PARITY    = "NO",
  parameter int    LEN_BYTES = 1,
  parameter int    MAX_LEN   = 256,
  parameter string CHK_MODE  = "SUM",
  parameter int    TIMEOUT   = 10,
  localparam int   AW        = (clog2(MAX_LEN) < 1) ? 1 : clog2(MAX_LEN),
  localparam int   LW        = (clog2(MAX_LEN + 1) < 1) ? 1 : clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_byte,
  input  logic          rx_valid,
  input  logic          rx_busy,
  output logic [7:0]    wr_data,
  output logic [AW-1:0] wr_addr,
  output logic          we,
  output logic          pkt_done,
  output logic          pkt_err,
  output logic [1:0]    err_code,
  output logic [7:0]    cmd_rx,
  output logic [LW-1:0] len_rx,
  output logic          busy
`ifdef UART_PKT_RX_STATS_EN
  ,
  output logic [15:0]   good_cnt,
  output logic [15:0]   err_cnt
`endif
);

  localparam int LFW     = 8 * LEN_BYTES;
  localparam int LIMIT   = TIMEOUT * (CLOCK / BAUD) * frame_bits(PARITY != "NO");
  localparam bit CHK_XOR = (CHK_MODE == "XOR");

  state_t         state, state_nx;
  logic [7:0]     acc, cmd_q, acc_fold;
  logic [LFW-1:0] len_field, len_next;
  logic [LW-1:0]  len_q;
  logic [AW-1:0]  idx;
  logic           lb_cnt;
  logic           expire;
  logic           len_last, len_over, data_last, chk_ok;
  logic           do_write, do_done, do_err;
  logic [1:0]     err_nx;

  uart_pkt_timeout #(.LIMIT(LIMIT)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .enable   (state != IDLE),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .expire   (expire)
  );

  // Length field is shifted in MSB first.
  assign len_next  = LFW'({len_field, rx_byte});
  assign len_last  = (lb_cnt == 1'(LEN_BYTES - 1));
  assign len_over  = (32'(len_next) > 32'(MAX_LEN));
  assign data_last = ((LW'(idx) + LW'(1)) == len_q);
  assign acc_fold  = CHK_XOR ? (acc ^ rx_byte) : (acc + rx_byte);
  assign chk_ok    = (rx_byte == (CHK_XOR ? acc : ~acc));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_write = 1'b0;
    do_done  = 1'b0;
    do_err   = 1'b0;
    err_nx   = ERR_NONE;
    case (state)
      IDLE: if (rx_valid) state_nx = LEN;
      LEN: begin
        if (rx_valid) begin
          if (len_last) begin
            if (len_over) begin
              state_nx = DROP;
              do_err   = 1'b1;
              err_nx   = ERR_LEN;
            end else if (len_next == '0) begin
              state_nx = CHK;
            end else begin
              state_nx = DATA;
            end
          end
        end else if (expire) begin
          state_nx = IDLE;
          do_err   = 1'b1;
          err_nx   = ERR_TIMEOUT;
        end
      end
      DATA: begin
        if (rx_valid) begin
          do_write = 1'b1;
          if (data_last) state_nx = CHK;
        end else if (expire) begin
          state_nx = IDLE;
          do_err   = 1'b1;
          err_nx   = ERR_TIMEOUT;
        end
      end
      CHK: begin
        if (rx_valid) begin
          state_nx = IDLE;
          if (chk_ok) begin
            do_done = 1'b1;
          end else begin
            do_err = 1'b1;
            err_nx = ERR_CHK;
          end
        end else if (expire) begin
          state_nx = IDLE;
          do_err   = 1'b1;
          err_nx   = ERR_TIMEOUT;
        end
      end
      // Oversized packet: swallow bytes silently until the line goes idle.
      DROP: if (expire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_data   <= '0;
      wr_addr   <= '0;
      we        <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= ERR_NONE;
      cmd_rx    <= '0;
      len_rx    <= '0;
      acc       <= '0;
      cmd_q     <= '0;
      len_field <= '0;
      len_q     <= '0;
      idx       <= '0;
      lb_cnt    <= 1'b0;
    end else begin
      we       <= do_write;
      pkt_done <= do_done;
      pkt_err  <= do_err;
      if (do_write) begin
        wr_data <= rx_byte;
        wr_addr <= idx;
      end
      if (do_err) err_code <= err_nx;
      if (do_done) begin
        cmd_rx <= cmd_q;
        len_rx <= len_q;
      end
      if (rx_valid) begin
        case (state)
          IDLE: begin
            cmd_q     <= rx_byte;
            acc       <= rx_byte;
            len_field <= '0;
            lb_cnt    <= 1'b0;
            idx       <= '0;
          end
          LEN: begin
            acc       <= acc_fold;
            len_field <= len_next;
            len_q     <= LW'(len_next);
            lb_cnt    <= lb_cnt + 1'b1;
          end
          DATA: begin
            acc <= acc_fold;
            idx <= idx + 1'b1;
          end
          CHK:     acc <= acc_fold;
          default: ;
        endcase
      end
    end
  end

`ifdef UART_PKT_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      good_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (pkt_done && (good_cnt != 16'hFFFF)) good_cnt <= good_cnt + 16'd1;
      if (pkt_err && (err_cnt != 16'hFFFF))   err_cnt  <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_pkt_rx.sv
// +--------------------------------------------------------------------------+
// | tb_uart_pkt_rx : randomized packet bench for uart_pkt_rx (two configs)   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_pkt_rx;

  localparam int LIM_A = 4 * 10 * 10;
  localparam int LIM_B = 2 * 10 * 11;
  localparam int MAX_A = 16;
  localparam int MAX_B = 256;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] rx_byte  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_busy  = 1'b0;
  logic       sel_b    = 1'b0;

  logic a_valid, a_busy_in, b_valid, b_busy_in;
  assign a_valid   = rx_valid & ~sel_b;
  assign a_busy_in = rx_busy & ~sel_b;
  assign b_valid   = rx_valid & sel_b;
  assign b_busy_in = rx_busy & sel_b;

  logic [7:0] a_data, b_data, a_cmd, b_cmd;
  logic [3:0] a_addr;
  logic [7:0] b_addr;
  logic [4:0] a_len;
  logic [8:0] b_len;
  logic       a_we, b_we, a_done, b_done, a_err, b_err, a_busy, b_busy;
  logic [1:0] a_code, b_code;
`ifdef UART_PKT_RX_STATS_EN
  logic [15:0] a_good, a_errc, b_good, b_errc;
`endif

  always #5 clk = ~clk;

  uart_pkt_rx #(
    .CLOCK(10_000_000), .BAUD(1_000_000), .PARITY("NO"), .LEN_BYTES(1),
    .MAX_LEN(MAX_A), .CHK_MODE("SUM"), .TIMEOUT(4)
  ) dut_a (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(a_valid), .rx_busy(a_busy_in),
    .wr_data(a_data), .wr_addr(a_addr), .we(a_we), .pkt_done(a_done), .pkt_err(a_err),
    .err_code(a_code), .cmd_rx(a_cmd), .len_rx(a_len), .busy(a_busy)
`ifdef UART_PKT_RX_STATS_EN
    , .good_cnt(a_good), .err_cnt(a_errc)
`endif
  );

  uart_pkt_rx #(
    .CLOCK(10_000_000), .BAUD(1_000_000), .PARITY("EVEN"), .LEN_BYTES(2),
    .MAX_LEN(MAX_B), .CHK_MODE("XOR"), .TIMEOUT(2)
  ) dut_b (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(b_valid), .rx_busy(b_busy_in),
    .wr_data(b_data), .wr_addr(b_addr), .we(b_we), .pkt_done(b_done), .pkt_err(b_err),
    .err_code(b_code), .cmd_rx(b_cmd), .len_rx(b_len), .busy(b_busy)
`ifdef UART_PKT_RX_STATS_EN
    , .good_cnt(b_good), .err_cnt(b_errc)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done, n_err, n_overlap;
  int          err_codes[$];
  logic [31:0] wlog[$];
  logic [7:0]  pay[$];
  int          exp_cmd[2], exp_len[2], exp_good[2], exp_bad[2];

  // Event monitor: records every write, completion and rejection of both DUTs.
  always @(negedge clk) begin
    if (a_we) wlog.push_back((32'(a_addr) << 8) | 32'(a_data));
    if (b_we) wlog.push_back((32'(b_addr) << 8) | 32'(b_data));
    if (a_done) n_done++;
    if (b_done) n_done++;
    if (a_err) begin n_err++; err_codes.push_back(int'(a_code)); end
    if (b_err) begin n_err++; err_codes.push_back(int'(b_code)); end
    if ((a_done && a_err) || (b_done && b_err)) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] v);
    rx_byte  = v;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    idle($urandom_range(0, 12));
  endtask

  task automatic clear_mon();
    n_done = 0;
    n_err  = 0;
    err_codes.delete();
    wlog.delete();
  endtask

  function automatic int first_code();
    return (err_codes.size() > 0) ? err_codes[0] : 99;
  endfunction

  function automatic logic [31:0] cur_cmd(input bit b);
    return b ? 32'(b_cmd) : 32'(a_cmd);
  endfunction

  function automatic logic [31:0] cur_len(input bit b);
    return b ? 32'(b_len) : 32'(a_len);
  endfunction

  function automatic logic cur_busy(input bit b);
    return b ? b_busy : a_busy;
  endfunction

  // mode 0: correct checksum, 1: corrupted checksum, 2: use chk_in as given.
  // When len exceeds the DUT limit, pay is sent as trailing junk instead of payload.
  task automatic run_pkt(input bit b, input logic [7:0] cmd, input int len,
                         input int mode, input logic [7:0] chk_in);
    logic [7:0] hdr[$];
    logic [7:0] s, x, good_chk, chk;
    int         maxl, lim;
    bit         over, ok;
    maxl  = b ? MAX_B : MAX_A;
    lim   = b ? LIM_B : LIM_A;
    sel_b = b;
    clear_mon();
    hdr.push_back(cmd);
    if (b) hdr.push_back(8'(len >> 8));
    hdr.push_back(8'(len));
    over = (len > maxl);
    s = 8'h00;
    x = 8'h00;
    foreach (hdr[i]) begin s = s + hdr[i]; x = x ^ hdr[i]; end
    foreach (pay[i]) begin s = s + pay[i]; x = x ^ pay[i]; end
    good_chk = b ? x : ~s;
    chk = (mode == 0) ? good_chk :
          (mode == 1) ? (good_chk ^ 8'($urandom_range(1, 255))) : chk_in;
    ok = (chk == good_chk);
    foreach (hdr[i]) send(hdr[i]);
    foreach (pay[i]) send(pay[i]);
    if (over) begin
      idle(lim + 30);
      check("guard_err_cnt", n_err, 1);
      check("guard_code", first_code(), 2);
      check("guard_writes", wlog.size(), 0);
      check("guard_done", n_done, 0);
      check("guard_idle", cur_busy(b), 0);
      exp_bad[b]++;
    end else begin
      send(chk);
      idle(4);
      check("done_cnt", n_done, ok ? 1 : 0);
      check("err_cnt", n_err, ok ? 0 : 1);
      if (!ok) check("chk_code", first_code(), 1);
      check("wr_count", wlog.size(), len);
      for (int i = 0; i < len && i < wlog.size(); i++)
        check("wr_addr_data", wlog[i], (32'(i) << 8) | 32'(pay[i]));
      if (ok) begin
        exp_cmd[b] = int'(cmd);
        exp_len[b] = len;
        exp_good[b]++;
      end else begin
        exp_bad[b]++;
      end
      check("cmd_rx", cur_cmd(b), exp_cmd[b]);
      check("len_rx", cur_len(b), exp_len[b]);
      check("busy_after", cur_busy(b), 0);
    end
  endtask

  task automatic fill_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic clear_expect();
    for (int i = 0; i < 2; i++) begin
      exp_cmd[i] = 0; exp_len[i] = 0; exp_good[i] = 0; exp_bad[i] = 0;
    end
  endtask

  task automatic check_stats();
`ifdef UART_PKT_RX_STATS_EN
    check("a_good_cnt", a_good, exp_good[0]);
    check("a_err_cnt", a_errc, exp_bad[0]);
    check("b_good_cnt", b_good, exp_good[1]);
    check("b_err_cnt", b_errc, exp_bad[1]);
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit b;
    int len;
    n_overlap = 0;
    clear_expect();
    clear_mon();
    idle(3);
    reset = 1'b0;
    check("rst_a_busy", a_busy, 0);
    check("rst_a_code", a_code, 0);
    check("rst_a_cmd", a_cmd, 0);
    check("rst_b_len", b_len, 0);
    idle(2);

    // Directed SUM packets on config A.
    pay = {8'hAA, 8'hBB};
    run_pkt(0, 8'h01, 2, 2, 8'h99);
    run_pkt(0, 8'h01, 2, 2, 8'h98);
    pay.delete();
    run_pkt(0, 8'h05, 0, 2, 8'hFA);
    fill_pay(MAX_A);
    run_pkt(0, 8'h3C, MAX_A, 0, 8'h00);
    fill_pay(6);
    run_pkt(0, 8'h07, 20, 0, 8'h00);
    fill_pay(3);
    run_pkt(0, 8'h08, 3, 0, 8'h00);
    fill_pay(2);
    run_pkt(0, 8'h09, MAX_A + 1, 0, 8'h00);

    // Directed XOR, two-byte length on config B.
    pay = {8'h01, 8'h02, 8'h03};
    run_pkt(1, 8'h10, 3, 2, 8'h13);
    check_stats();

    // Inter-byte timeout in DATA.
    sel_b = 1'b0;
    clear_mon();
    rx_byte = 8'h33; rx_valid = 1'b1; idle(1);
    rx_byte = 8'h04; idle(1);
    rx_byte = 8'h44; idle(1);
    rx_valid = 1'b0;
    idle(LIM_A - 20);
    check("to_early", n_err, 0);
    idle(40);
    check("to_err_cnt", n_err, 1);
    check("to_code", first_code(), 3);
    check("to_writes", wlog.size(), 1);
    check("to_idle", a_busy, 0);
    exp_bad[0]++;

    // rx_busy held across the limit freezes the timeout.
    clear_mon();
    rx_byte = 8'h33; rx_valid = 1'b1; idle(1);
    rx_byte = 8'h04; idle(1);
    rx_byte = 8'h44; idle(1);
    rx_valid = 1'b0;
    idle(5);
    rx_busy = 1'b1;
    idle(LIM_A + 50);
    check("busy_hold_err", n_err, 0);
    check("busy_hold_busy", a_busy, 1);
    rx_busy = 1'b0;
    idle(LIM_A + 20);
    check("busy_rel_err", n_err, 1);
    check("busy_rel_code", first_code(), 3);
    exp_bad[0]++;
    check_stats();

    // Randomized packets on both configurations.
    for (int t = 0; t < 30; t++) begin
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        len = b ? int'($urandom_range(MAX_B + 1, 65535)) : int'($urandom_range(MAX_A + 1, 255));
        fill_pay($urandom_range(0, 4));
      end else begin
        len = b ? int'($urandom_range(0, 20)) : int'($urandom_range(0, MAX_A));
        fill_pay(len);
      end
      run_pkt(b, 8'($urandom_range(0, 255)), len, ($urandom_range(0, 3) == 0) ? 1 : 0, 8'h00);
    end
    check_stats();

    // Reset in the middle of DATA discards the packet silently.
    sel_b = 1'b0;
    clear_mon();
    rx_byte = 8'h21; rx_valid = 1'b1; idle(1);
    rx_byte = 8'h05; idle(1);
    rx_byte = 8'h5A; idle(1);
    rx_byte = 8'hA5; idle(1);
    rx_valid = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    clear_expect();
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_we", a_we, 0);
    check("mid_rst_code", a_code, 0);
    check("mid_rst_cmd", a_cmd, 0);
    check("mid_rst_len", a_len, 0);
    check("mid_rst_wr", {a_addr, a_data}, 0);
    idle(3);
    check("mid_rst_no_err", n_err, 0);
    fill_pay(4);
    run_pkt(0, 8'h66, 4, 0, 8'h00);
    check_stats();

    check("done_err_overlap", n_overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
